// File: rtl/dec_arbiter.sv
// dec_arbiter: round-robin arbiter/sequencer sharing one external signed
// decrementer between NREQ requesters.
//   Clk, Rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester handshake, req_ready is a one-hot grant
//   req_data            packed operands, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   dec_a / dec_d       registered operand out, combinational result back in
//   rsp_valid/rsp_ready response handshake
//   rsp_data/rsp_id/rsp_ovf  result, requester index, wrap/clamp flag
//   busy                high while an operation is in flight or awaiting accept
module dec_arbiter #(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned SAT       = 0,
   parameter int unsigned IDW       = $clog2(NREQ)
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DATAWIDTH-1:0] req_data,
   output logic [NREQ-1:0]           req_ready,
   output logic [DATAWIDTH-1:0]      dec_a,
   input  logic [DATAWIDTH-1:0]      dec_d,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATAWIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]            rsp_id,
   output logic                      rsp_ovf,
   output logic                      busy
);

   localparam int unsigned DW = DATAWIDTH;
   localparam int unsigned NR = NREQ;
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IDW-1:0]  last;
   logic [IDW-1:0]  id_q;

   logic            pick_found;
   logic [IDW-1:0]  pick_idx;
   logic [DW-1:0]   pick_data;
   logic            grant_en;
   logic            load;
   logic            sat_hit;

   // State register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Round-robin pick, next state and grant decode
   always_comb begin
      state_nxt  = state;
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_data  = '0;
      grant_en   = 1'b0;
      load       = 1'b0;
      req_ready  = '0;

      // Scan from farthest to nearest so the nearest valid index after last wins
      for (int k = int'(NR); k >= 1; k--) begin
         if (req_valid[IDW'((32'(last) + 32'(k)) % NR)]) begin
            pick_found = 1'b1;
            pick_idx   = IDW'((32'(last) + 32'(k)) % NR);
         end
      end

      for (int unsigned i = 0; i < NR; i++) begin
         if (pick_idx == IDW'(i)) begin
            pick_data = req_data[i*DW +: DW];
         end
      end

      case (state)
         IDLE: begin
            grant_en = 1'b1;
            if (pick_found) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               grant_en  = 1'b1;
               state_nxt = pick_found ? EXEC : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      load = grant_en & pick_found;
      // Grant is suppressed while reset is held so no transfer is claimed
      if (load && Rst) begin
         req_ready = NR'(1) << pick_idx;
      end
   end

   assign sat_hit = (SAT != 0) && (dec_a == MOST_NEG);

   // Operand, ID, priority pointer and response registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         last      <= IDW'(NR - 1);
         id_q      <= '0;
         dec_a     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_ovf   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         if (state == EXEC) begin
            rsp_data  <= sat_hit ? MOST_NEG : dec_d;
            rsp_ovf   <= (dec_a == MOST_NEG);
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         if (load) begin
            dec_a <= pick_data;
            id_q  <= pick_idx;
            last  <= pick_idx;
         end
      end
   end

endmodule
